// File: rtl/serial_adder_ctrl_pkg.sv
// serial_adder_ctrl_pkg: shared FSM encodings and default width for the serial adder
package serial_adder_ctrl_pkg;
  localparam int WIDTH_DEF = 8;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/FullAdder.sv
// FullAdder: 1-bit full-adder cell
module FullAdder (
  output logic Sum,
  output logic Cout,
  input  logic A,
  input  logic B,
  input  logic Cin
);
  assign Sum  = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: LSB-first bit-serial adder, one full-adder cell per cycle
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);
  localparam int CW = $clog2(WIDTH) + 1;
  state_t state, state_n;
  logic [WIDTH-1:0] a_sr, b_sr, s_sr;
  logic carry, fa_s, fa_c, last;
  logic [CW-1:0] cnt;
  FullAdder u_fa (
    .Sum (fa_s),
    .Cout(fa_c),
    .A   (a_sr[0]),
    .B   (b_sr[0]),
    .Cin (carry)
  );
  assign last = cnt == CW'(WIDTH - 1);
  assign busy = state == RUN;
  assign done = state == DONE;
  always_comb begin
    state_n = IDLE;
    state_n = state == IDLE ? (start ? RUN : IDLE) :
              state == RUN  ? (last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      s_sr  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      Sum   <= '0;
      Cout  <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        a_sr  <= A;
        b_sr  <= B;
        carry <= Cin;
        cnt   <= '0;
      end else if (state == RUN) begin
        a_sr  <= a_sr >> 1;
        b_sr  <= b_sr >> 1;
        s_sr  <= {fa_s, s_sr[WIDTH-1:1]};
        carry <= fa_c;
        cnt   <= cnt + 1'b1;
        if (last) begin
          Sum  <= {fa_s, s_sr[WIDTH-1:1]};
          Cout <= fa_c;
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: scoreboard bench for the bit-serial adder at WIDTH=8
module tb_serial_adder_ctrl;
  logic clk = 1'b0;
  logic rst, start, Cin, busy, done, Cout;
  logic [7:0] A, B, Sum;
  logic [8:0] sb[$];
  int passed = 0, total = 0, done_cnt = 0;

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .Cin(Cin),
    .busy(busy), .done(done), .Sum(Sum), .Cout(Cout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst === 1'b0 && done === 1'b1) begin
      logic [8:0] exp;
      done_cnt++;
      total++;
      if (sb.size() == 0) begin
        $display("FAIL sb_unexpected_done got cout=%b sum=%h, no result expected", Cout, Sum);
      end else begin
        exp = sb.pop_front();
        if ({Cout, Sum} !== exp)
          $display("FAIL sb_result got cout=%b sum=%h, expected cout=%b sum=%h", Cout, Sum, exp[8], exp[7:0]);
        else
          passed++;
      end
    end
  end

  function automatic logic [8:0] model(input logic [7:0] a, b, input logic c);
    return {1'b0, a} + {1'b0, b} + {8'd0, c};
  endfunction

  task automatic start_op(input logic [7:0] a, b, input logic c);
    @(negedge clk);
    A = a; B = b; Cin = c; start = 1'b1;
    sb.push_back(model(a, b, c));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, output bit ok);
    ok = 1'b0;
    repeat (40) begin
      @(negedge clk); #1;
      if (done_cnt != d0) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; A = '0; B = '0; Cin = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, done, Cout, Sum} !== 11'd0)
      $display("FAIL reset_state got busy=%b done=%b cout=%b sum=%h, expected all 0", busy, done, Cout, Sum);
    else passed++;
    rst = 1'b0;
  endtask

  task automatic test_zero_latency;
    int busy_n = 0, done_n = 0, d0 = done_cnt;
    @(negedge clk);
    A = 8'h00; B = 8'h00; Cin = 1'b0; start = 1'b1;
    sb.push_back(model(8'h00, 8'h00, 1'b0));
    for (int n = 1; n <= 15; n++) begin
      @(negedge clk); #1;
      start = 1'b0;
      if (busy === 1'b1) busy_n++;
      if (done === 1'b1 && done_n == 0) done_n = n;
    end
    total++;
    if (busy_n != 8) $display("FAIL zero_busy_cycles got %0d, expected 8", busy_n);
    else passed++;
    total++;
    if (done_n != 9) $display("FAIL zero_done_cycle got %0d, expected 9", done_n);
    else passed++;
    total++;
    if (done_cnt - d0 != 1) $display("FAIL zero_done_count got %0d, expected 1", done_cnt - d0);
    else passed++;
  endtask

  task automatic test_carry;
    bit ok;
    start_op(8'hFF, 8'h01, 1'b0);
    wait_done(done_cnt - 0, ok);
    total++;
    if (!ok) $display("FAIL carry_ff_timeout got no done, expected done");
    else passed++;
    start_op(8'h7F, 8'h01, 1'b0);
    wait_done(done_cnt, ok);
    total++;
    if (!ok) $display("FAIL carry_7f_timeout got no done, expected done");
    else passed++;
    total++;
    if ({Cout, Sum} !== 9'h080) $display("FAIL carry_7f_hold got %h, expected 080", {Cout, Sum});
    else passed++;
  endtask

  task automatic test_operand_change;
    bit ok;
    int d0 = done_cnt;
    start_op(8'hA5, 8'h5A, 1'b1);
    @(negedge clk);
    A = 8'h00; B = 8'h00; Cin = 1'b0;
    wait_done(d0, ok);
    total++;
    if (!ok || {Cout, Sum} !== 9'h100)
      $display("FAIL operand_change got ok=%b %h, expected 100", ok, {Cout, Sum});
    else passed++;
  endtask

  task automatic test_start_ignored;
    int busy_n = 0, done_n = 0, d0 = done_cnt;
    @(negedge clk);
    A = 8'h3C; B = 8'h21; Cin = 1'b1; start = 1'b1;
    sb.push_back(model(8'h3C, 8'h21, 1'b1));
    for (int n = 1; n <= 25; n++) begin
      @(negedge clk); #1;
      start = (n == 3);
      if (n == 3) begin A = 8'hFF; B = 8'hFF; end
      if (busy === 1'b1) busy_n++;
      if (done === 1'b1 && done_n == 0) done_n = n;
    end
    total++;
    if (done_n != 9 || done_cnt - d0 != 1)
      $display("FAIL start_ignored got done_at=%0d dones=%0d, expected 9 and 1", done_n, done_cnt - d0);
    else passed++;
    total++;
    if (busy_n != 8) $display("FAIL start_ignored_busy got %0d, expected 8", busy_n);
    else passed++;
  endtask

  task automatic test_reset_abort;
    bit ok;
    int d0;
    start_op(8'h12, 8'h34, 1'b0);
    wait_done(done_cnt, ok);
    total++;
    if (!ok || Sum !== 8'h46) $display("FAIL abort_setup got ok=%b sum=%h, expected 46", ok, Sum);
    else passed++;
    d0 = done_cnt;
    @(negedge clk);
    A = 8'hF0; B = 8'h0F; Cin = 1'b1; start = 1'b1;
    sb.push_back(model(8'hF0, 8'h0F, 1'b1));
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk); #1;
      start = 1'b0;
      if (n == 4) rst = 1'b1;
    end
    total++;
    if ({busy, done, Cout, Sum} !== 11'd0)
      $display("FAIL abort_state got busy=%b done=%b cout=%b sum=%h, expected all 0", busy, done, Cout, Sum);
    else passed++;
    rst = 1'b0;
    sb.delete();
    repeat (20) @(negedge clk);
    total++;
    if (done_cnt != d0) $display("FAIL abort_no_done got %0d dones, expected 0", done_cnt - d0);
    else passed++;
  endtask

  task automatic test_back_to_back;
    bit ok;
    logic [7:0] a, b;
    @(negedge clk);
    A = 8'h11; B = 8'h22; Cin = 1'b0; start = 1'b1;
    sb.push_back(model(8'h11, 8'h22, 1'b0));
    for (int k = 0; k < 3; k++) begin
      wait_done(done_cnt, ok);
      total++;
      if (!ok) $display("FAIL b2b_timeout op %0d got no done, expected done", k);
      else passed++;
      if (k < 2) begin
        a = 8'(k * 8'h40 + 8'h0F); b = 8'(8'hC3 - k);
        A = a; B = b; Cin = k[0];
        sb.push_back(model(a, b, k[0]));
      end else start = 1'b0;
      @(negedge clk); #1;
      total++;
      if (busy !== 1'b0 || done !== 1'b0)
        $display("FAIL b2b_idle_gap op %0d got busy=%b done=%b, expected 0 0", k, busy, done);
      else passed++;
      if (k < 2) begin
        @(negedge clk); #1;
        total++;
        if (busy !== 1'b1) $display("FAIL b2b_restart op %0d got busy=%b, expected 1", k, busy);
        else passed++;
      end
    end
  endtask

  task automatic test_random;
    bit ok;
    int miss = 0;
    for (int i = 0; i < 1000; i++) begin
      start_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      wait_done(done_cnt, ok);
      if (!ok) miss++;
    end
    total++;
    if (miss != 0) $display("FAIL random_timeouts got %0d, expected 0", miss);
    else passed++;
    total++;
    if (sb.size() != 0) $display("FAIL sb_leftover got %0d, expected 0", sb.size());
    else passed++;
  endtask

  initial begin
    test_reset();
    test_zero_latency();
    test_carry();
    test_operand_change();
    test_start_ignored();
    test_reset_abort();
    test_back_to_back();
    test_random();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
